// File: rtl/camera_capture_ctrl.sv
// rtl/camera_capture_ctrl.sv - OV7670 frame capture sequencer driving frame-buffer writes.
// Define CAPTURE_GEOM_CHECK_EN to build per-line / per-frame geometry checking.
module camera_capture_ctrl #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int ADDR_W   = 19
) (
  input  logic              p_clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic              continuous,
  input  logic              abort,
  input  logic              vsync,
  input  logic              href,
  input  logic [15:0]       pixel_data,
  input  logic              pixel_valid,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_data,
  output logic              busy,
  output logic              capture_done,
  output logic              frame_err,
  output logic [7:0]        frame_count
);

  typedef enum logic [2:0] {S_IDLE, S_ARM, S_SYNC, S_CAPTURE, S_END} state_t;

  // One extra address bit so the counter can sit at exactly H_ACTIVE*V_ACTIVE.
  localparam logic [ADDR_W:0] FRAME_PIXELS = (ADDR_W+1)'(H_ACTIVE * V_ACTIVE);

  state_t            state_q, state_d;
  logic              vsync_q;
  logic [ADDR_W:0]   addr_q, addr_d;
  logic              ovf_q, ovf_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [15:0]       wr_data_q, wr_data_d;
  logic              done_q, done_d;
  logic              ferr_q, ferr_d;
  logic [7:0]        fcnt_q, fcnt_d;
  logic              vsync_rise;

  assign vsync_rise = vsync & ~vsync_q;

`ifdef CAPTURE_GEOM_CHECK_EN
  localparam int PW = $clog2(H_ACTIVE + 1) + 1;
  localparam int LW = $clog2(V_ACTIVE + 1) + 1;
  logic          href_q;
  logic          href_fall;
  logic [PW-1:0] pix_q, pix_d;
  logic [LW-1:0] line_q, line_d;
  logic          gerr_q, gerr_d;

  assign href_fall = ~href & href_q;
`else
  logic unused_href;
  assign unused_href = href;
`endif

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    ovf_d     = ovf_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    done_d    = 1'b0;
    ferr_d    = 1'b0;
    fcnt_d    = fcnt_q;
`ifdef CAPTURE_GEOM_CHECK_EN
    pix_d     = pix_q;
    line_d    = line_q;
    gerr_d    = gerr_q;
`endif
    case (state_q)
      S_IDLE:  if (start) state_d = S_ARM;
      S_ARM:   if (vsync_rise) state_d = S_SYNC;
      S_SYNC: begin
        if (!vsync) begin
          state_d = S_CAPTURE;
          addr_d  = '0;
          ovf_d   = 1'b0;
`ifdef CAPTURE_GEOM_CHECK_EN
          pix_d   = '0;
          line_d  = '0;
          gerr_d  = 1'b0;
`endif
        end
      end
      S_CAPTURE: begin
        if (pixel_valid) begin
          if (addr_q < FRAME_PIXELS) begin
            wr_en_d   = 1'b1;
            wr_addr_d = addr_q[ADDR_W-1:0];
            wr_data_d = pixel_data;
            addr_d    = addr_q + (ADDR_W+1)'(1);
          end else begin
            ovf_d = 1'b1;
          end
        end
`ifdef CAPTURE_GEOM_CHECK_EN
        // Counters saturate so a runaway frame cannot wrap back to a legal count.
        if (pixel_valid && pix_q != '1) pix_d = pix_q + PW'(1);
        if (href_fall) begin
          if (pix_d != PW'(H_ACTIVE)) gerr_d = 1'b1;
          pix_d = '0;
          if (line_q != '1) line_d = line_q + LW'(1);
        end
`endif
        if (vsync_rise) begin
          state_d = S_END;
          done_d  = 1'b1;
          fcnt_d  = fcnt_q + 8'd1;
`ifdef CAPTURE_GEOM_CHECK_EN
          ferr_d  = ovf_d | gerr_d | (line_d != LW'(V_ACTIVE));
`else
          ferr_d  = ovf_d;
`endif
        end
      end
      S_END:   state_d = continuous ? S_SYNC : S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort) begin
      state_d = S_IDLE;
      wr_en_d = 1'b0;
      done_d  = 1'b0;
      ferr_d  = 1'b0;
      fcnt_d  = fcnt_q;
    end
  end

  always_ff @(posedge p_clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      vsync_q   <= 1'b0;
      addr_q    <= '0;
      ovf_q     <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
      ferr_q    <= 1'b0;
      fcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      vsync_q   <= vsync;
      addr_q    <= addr_d;
      ovf_q     <= ovf_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      done_q    <= done_d;
      ferr_q    <= ferr_d;
      fcnt_q    <= fcnt_d;
    end
  end

`ifdef CAPTURE_GEOM_CHECK_EN
  always_ff @(posedge p_clock or negedge reset_n) begin
    if (!reset_n) begin
      href_q <= 1'b0;
      pix_q  <= '0;
      line_q <= '0;
      gerr_q <= 1'b0;
    end else begin
      href_q <= href;
      pix_q  <= pix_d;
      line_q <= line_d;
      gerr_q <= gerr_d;
    end
  end
`endif

  assign wr_en        = wr_en_q;
  assign wr_addr      = wr_addr_q;
  assign wr_data      = wr_data_q;
  assign busy         = (state_q != S_IDLE);
  assign capture_done = done_q;
  assign frame_err    = ferr_q;
  assign frame_count  = fcnt_q;

endmodule

// File: tb/tb_camera_capture_ctrl.sv
// tb/tb_camera_capture_ctrl.sv - directed self-checking bench for camera_capture_ctrl.
module tb_camera_capture_ctrl;

  logic        p_clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0, continuous = 1'b0, abort = 1'b0;
  logic        vsync = 1'b0, href = 1'b0;
  logic [15:0] pixel_data = '0;
  logic        pixel_valid = 1'b0;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [15:0] wr_data;
  logic        busy, capture_done, frame_err;
  logic [7:0]  frame_count;

  int          n_checks = 0;
  int          n_pass = 0;
  logic [2:0]  sb_addr[$];
  logic [15:0] sb_data[$];
  int          n_done = 0;
  int          n_err = 0;
  logic [15:0] pix_val = 16'd1;
  int          exp_short_err;

  camera_capture_ctrl #(.H_ACTIVE(4), .V_ACTIVE(2), .ADDR_W(3)) dut (
    .p_clock(p_clock), .reset_n(reset_n), .start(start), .continuous(continuous),
    .abort(abort), .vsync(vsync), .href(href), .pixel_data(pixel_data),
    .pixel_valid(pixel_valid), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .capture_done(capture_done), .frame_err(frame_err),
    .frame_count(frame_count)
  );

  always #5 p_clock = ~p_clock;

  always @(negedge p_clock) begin
    if (wr_en) begin
      sb_addr.push_back(wr_addr);
      sb_data.push_back(wr_data);
    end
    if (capture_done) n_done++;
    if (frame_err) n_err++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge p_clock);
    #1;
  endtask

  task automatic clear_sb();
    sb_addr.delete();
    sb_data.delete();
    n_done = 0;
    n_err  = 0;
  endtask

  task automatic vsync_pulse();
    vsync = 1'b1;
    tick(3);
    vsync = 1'b0;
    tick(2);
  endtask

  task automatic send_pixels(input int n);
    for (int i = 0; i < n; i++) begin
      pixel_data  = pix_val;
      pix_val     = pix_val + 16'd1;
      pixel_valid = 1'b1;
      tick(1);
      pixel_valid = 1'b0;
      tick(1);
    end
  endtask

  task automatic send_line(input int n);
    href = 1'b1;
    tick(1);
    send_pixels(n);
    href = 1'b0;
    tick(2);
  endtask

  task automatic do_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  initial begin
    tick(3);
    reset_n = 1'b1;
    tick(1);
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", capture_done, 0);
    check("rst_err", frame_err, 0);
    check("rst_fcnt", frame_count, 0);

    // start and abort together: stays idle
    start = 1'b1; abort = 1'b1;
    tick(1);
    start = 1'b0; abort = 1'b0;
    check("start_abort_busy", busy, 0);

    // single-shot nominal
    clear_sb(); pix_val = 16'd1;
    do_start();
    check("s1_busy_rise", busy, 1);
    vsync_pulse();
    send_line(4);
    send_line(4);
    vsync_pulse();
    check("s1_nwr", sb_addr.size(), 8);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("s1_addr%0d", i), sb_addr[i], i);
      check($sformatf("s1_data%0d", i), sb_data[i], i + 1);
    end
    check("s1_done", n_done, 1);
    check("s1_err", n_err, 0);
    check("s1_fcnt", frame_count, 1);
    check("s1_busy_fall", busy, 0);

    // continuous, 3 frames, dropped before the third end
    clear_sb(); pix_val = 16'h0100;
    continuous = 1'b1;
    do_start();
    vsync_pulse();
    for (int f = 0; f < 3; f++) begin
      send_line(4);
      send_line(4);
      if (f == 2) continuous = 1'b0;
      vsync_pulse();
      if (f < 2) check($sformatf("s2_busy_f%0d", f), busy, 1);
    end
    check("s2_done", n_done, 3);
    check("s2_nwr", sb_addr.size(), 24);
    check("s2_addr8", sb_addr[8], 0);
    check("s2_addr16", sb_addr[16], 0);
    check("s2_addr23", sb_addr[23], 7);
    check("s2_data16", sb_data[16], 16'h0110);
    check("s2_fcnt", frame_count, 4);
    check("s2_busy_end", busy, 0);

    // short second line
    clear_sb();
`ifdef CAPTURE_GEOM_CHECK_EN
    exp_short_err = 1;
`else
    exp_short_err = 0;
`endif
    do_start();
    vsync_pulse();
    send_line(4);
    send_line(3);
    vsync_pulse();
    check("s3_done", n_done, 1);
    check("s3_err", n_err, exp_short_err);
    check("s3_fcnt", frame_count, 5);

    // overflow: 3 lines of 4
    clear_sb(); pix_val = 16'h0200;
    do_start();
    vsync_pulse();
    send_line(4);
    send_line(4);
    send_line(4);
    vsync_pulse();
    check("s4_nwr", sb_addr.size(), 8);
    check("s4_last_addr", sb_addr[7], 7);
    check("s4_wr_addr_hold", wr_addr, 7);
    check("s4_last_data", wr_data, 16'h0207);
    check("s4_done", n_done, 1);
    check("s4_err", n_err, 1);
    check("s4_fcnt", frame_count, 6);

    // abort after 5 pixels
    clear_sb();
    do_start();
    vsync_pulse();
    send_line(4);
    href = 1'b1;
    tick(1);
    send_pixels(1);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    check("s5_busy", busy, 0);
    send_pixels(3);
    href = 1'b0;
    tick(2);
    vsync_pulse();
    check("s5_nwr", sb_addr.size(), 5);
    check("s5_done", n_done, 0);
    check("s5_fcnt", frame_count, 6);

    // asynchronous reset mid-capture
    clear_sb();
    do_start();
    vsync_pulse();
    href = 1'b1;
    tick(1);
    send_pixels(2);
    #3 reset_n = 1'b0;
    #1;
    check("s6_rst_busy", busy, 0);
    check("s6_rst_wr_en", wr_en, 0);
    check("s6_rst_wr_addr", wr_addr, 0);
    check("s6_rst_wr_data", wr_data, 0);
    check("s6_rst_fcnt", frame_count, 0);
    #2 reset_n = 1'b1;
    @(posedge p_clock);
    #1;
    clear_sb();
    send_pixels(2);
    href = 1'b0;
    tick(2);
    vsync_pulse();
    send_line(4);
    vsync_pulse();
    check("s6_ign_nwr", sb_addr.size(), 0);
    check("s6_ign_done", n_done, 0);
    check("s6_ign_busy", busy, 0);
    clear_sb(); pix_val = 16'h0300;
    do_start();
    vsync_pulse();
    send_line(4);
    send_line(4);
    vsync_pulse();
    check("s6_new_nwr", sb_addr.size(), 8);
    check("s6_new_data0", sb_data[0], 16'h0300);
    check("s6_new_done", n_done, 1);
    check("s6_new_fcnt", frame_count, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/camera_capture_ctrl.md
# camera_capture_ctrl

Sequencing controller for the OV7670 capture path. Sits between the camera byte-pairing stage (`pixel_data` / `pixel_valid`) and the frame buffer. It:
- arms on request and synchronises to a frame boundary on `vsync`;
- generates frame-buffer write address, enable and data for exactly one frame (single-shot) or back-to-back frames (continuous);
- reports completion, frame count and geometry errors.

## Interface
- `H_ACTIVE`, 640, pixels per line expected
- `V_ACTIVE`, 480, lines per frame expected
- `ADDR_W`, 19, frame-buffer address width; must satisfy 2^ADDR_W >= H_ACTIVE*V_ACTIVE
- `p_clock` in 1: pixel clock; all logic on rising edge
- `reset_n` in 1: asynchronous, active-low reset
- `start` in 1: capture request, sampled in IDLE only
- `continuous` in 1: sampled at each frame end; 1 = re-arm automatically
- `abort` in 1: stop immediately, any state
- `vsync` in 1: camera vsync, high between frames
- `href` in 1: camera href, high during active line
- `pixel_data` in 16: RGB565 pixel from byte-pairing stage
- `pixel_valid` in 1: one-cycle strobe per pixel
- `wr_en` out 1: frame-buffer write strobe
- `wr_addr` out ADDR_W: write address, linear raster order
- `wr_data` out 16: write data
- `busy` out 1: high in any state except IDLE
- `capture_done` out 1: one-cycle pulse at end of each captured frame
- `frame_err` out 1: one-cycle pulse coincident with `capture_done` on geometry mismatch
- `frame_count` out 8: completed frames since reset, wraps 255->0

## Operation
- `vsync` and `href` are registered once (`vsync_q`, `href_q`).
  - rise = `vsync & ~vsync_q`
  - href fall = `~href & href_q`
- States:
  - **IDLE**
    - `start` & ~`abort` -> ARM
  - **ARM**: wait for a frame boundary
    - vsync rise -> SYNC
  - **SYNC**: wait for the vsync pulse to end
    - `vsync` low -> CAPTURE; clear address, pixel and line counters
  - **CAPTURE**
    - each `pixel_valid` with address < H_ACTIVE*V_ACTIVE: write `pixel_data` at current address, then address+1
    - `pixel_valid` at address = H_ACTIVE*V_ACTIVE: write suppressed; address holds; overflow flag set
    - href fall: line counter+1, pixel-in-line counter cleared
    - vsync rise -> END
  - **END** (one cycle)
    - pulse `capture_done`; `frame_count`+1
    - `continuous`=1 -> SYNC (the boundary already occurred)
    - otherwise -> IDLE
- `abort` in any non-IDLE state -> IDLE next cycle.
  - No `capture_done`, no `frame_count` change.
  - `wr_en` low from the next cycle.
- `start` while busy is ignored. `start` and `abort` together in IDLE: abort wins, stay IDLE.
- `pixel_valid` in the same cycle as a vsync rise in CAPTURE: the pixel is written, then END.
- `pixel_valid` outside CAPTURE is ignored.
- Reset values:
  - state IDLE; `wr_en`, `busy`, `capture_done`, `frame_err` 0
  - `wr_addr` 0, `wr_data` 0, `frame_count` 0
  - all counters 0
- Reset mid-frame discards the frame. After release, capture requires a new `start`.

## Timing
- `pixel_valid` at cycle N -> `wr_en`, `wr_addr`, `wr_data` registered, valid at N+1. `wr_en` is high for exactly one cycle per pixel.
- `busy` rises the cycle after `start` is accepted and falls the cycle after END (single-shot) or after `abort`.
- vsync rise in CAPTURE at cycle N -> END at N+1. `capture_done`/`frame_err` are high during N+1 only.
- Minimum arm-to-first-write latency: vsync rise + vsync pulse width + 2 cycles.

## Configuration
- `CAPTURE_GEOM_CHECK_EN` defined:
  - pixel-in-line counter and line counter are built.
  - A frame error is recorded if any line ends with pixel count != H_ACTIVE, or the frame ends with line count != V_ACTIVE, or overflow occurred.
  - `frame_err` pulses with `capture_done` if any error was recorded.
- Not defined:
  - line and pixel counters are omitted.
  - `frame_err` pulses only on overflow.
- In both builds, write suppression at overflow is unchanged.

## Test plan
All scenarios use H_ACTIVE=4, V_ACTIVE=2, ADDR_W=3.

- **Single-shot, nominal:** `start`; vsync pulse; 2 lines x 4 valid pixels 0x0001..0x0008; vsync rise.
  - Writes to addresses 0..7 with data 0x0001..0x0008.
  - `capture_done` 1 cycle; `frame_err` 0; `frame_count`=1; `busy` low after END.
- **Continuous, 3 frames:** `continuous`=1.
  - `capture_done` ×3; `frame_count`=3.
  - Address restarts at 0 each frame; `busy` stays high.
  - Drop `continuous` -> IDLE after the next frame.
- **Short line:** line 2 has 3 pixels.
  - With `CAPTURE_GEOM_CHECK_EN`: `frame_err`=1 with `capture_done`.
  - Without: `frame_err`=0.
- **Overflow:** 3 lines of 4 pixels.
  - Only addresses 0..7 written; `wr_addr` holds at 7.
  - `frame_err`=1 in both builds.
- **Abort mid-frame:** `abort` after 5 pixels.
  - IDLE next cycle; no further `wr_en`; `capture_done` never pulses; `frame_count` unchanged.
- **Asynchronous reset:** `reset_n` low for 3 ns mid-CAPTURE, not aligned to a clock edge.
  - All outputs 0 immediately.
  - Later pixels ignored until a new `start`.
